// File: rtl/param_commit_sched_pkg.sv
// param_commit_sched_pkg: slot indices, reset defaults and FSM encoding for the parameter commit scheduler.
package param_commit_sched_pkg;
    localparam int NSLOT_DEF = 5;
    localparam int W_DEF = 32;
    localparam int SLOT_LTP = 0;
    localparam int SLOT_LTD = 1;
    localparam int SLOT_PDELTA = 2;
    localparam int SLOT_GAIN = 3;
    localparam int SLOT_CLKDIV = 4;
    localparam logic [NSLOT_DEF*W_DEF-1:0] INIT_DEFAULT = {32'd0, 32'd1024, 32'd0, 32'd0, 32'd0};
    typedef enum logic {IDLE, COMMIT} state_t;
endpackage

// File: rtl/param_commit_sched_slot.sv
// param_slot: staging register, pending bit and overwrite detect for one parameter slot.
module param_slot
    import param_commit_sched_pkg::*;
#(
    parameter int W = W_DEF,
    parameter logic [W-1:0] INIT_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         trig,
    input  logic [W-1:0] data_in,
    input  logic         commit,
    output logic [W-1:0] stage,
    output logic         pending,
    output logic         ovf_hit
);
    // A write landing on the cycle this slot commits re-arms it rather than overwriting.
    assign ovf_hit = trig && pending && !commit;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage <= INIT_VAL;
            pending <= 1'b0;
        end else begin
            if (trig) stage <= data_in;
            pending <= trig || (pending && !commit);
        end
    end
endmodule

// File: rtl/param_commit_sched.sv
// param_commit_sched: stages host parameter writes and commits them in slot order on each sim_tick.
module param_commit_sched
    import param_commit_sched_pkg::*;
#(
    parameter int NSLOT = NSLOT_DEF,
    parameter int W = W_DEF,
    parameter logic [NSLOT*W-1:0] INIT = INIT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NSLOT-1:0]   trig,
    input  logic [W-1:0]       data_in,
    input  logic               sim_tick,
    input  logic               clr_ovf,
    output logic [NSLOT*W-1:0] param_out,
    output logic               cfg_we,
    output logic [2:0]         cfg_addr,
    output logic [W-1:0]       cfg_data,
    output logic [NSLOT-1:0]   pending,
    output logic               busy,
    output logic               done,
    output logic               ovf
);
    localparam logic [2:0] LAST = 3'(NSLOT - 1);
    state_t state;
    logic [2:0] ptr, ptr_nx;
    logic go, adv, hit;
    logic [W-1:0] stage [NSLOT];
    logic [W-1:0] val [NSLOT];
    logic [NSLOT-1:0] commit, ovf_hit;
    genvar i;
    generate
        for (i = 0; i < NSLOT; i++) begin : g_slot
            assign commit[i] = cfg_we && cfg_addr == 3'(i);
            assign param_out[i*W +: W] = val[i];
            param_slot #(.W(W), .INIT_VAL(INIT[i*W +: W])) u_slot (
                .clk(clk),
                .reset_n(reset_n),
                .trig(trig[i]),
                .data_in(data_in),
                .commit(commit[i]),
                .stage(stage[i]),
                .pending(pending[i]),
                .ovf_hit(ovf_hit[i])
            );
        end
    endgenerate
    // The cfg port is loaded one cycle ahead from next-state slot contents so slot k writes while ptr==k.
    always_comb begin
        go = state == IDLE && sim_tick && |(pending | trig);
        adv = go || (state == COMMIT && ptr != LAST);
        ptr_nx = (state == COMMIT && ptr != LAST) ? ptr + 3'd1 : 3'd0;
        hit = adv && (pending[ptr_nx] || trig[ptr_nx]);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr <= 3'd0;
            busy <= 1'b0;
            done <= 1'b0;
            ovf <= 1'b0;
            cfg_we <= 1'b0;
            cfg_addr <= 3'd0;
            cfg_data <= '0;
            for (int k = 0; k < NSLOT; k++) val[k] <= INIT[k*W +: W];
        end else begin
            state <= adv ? COMMIT : IDLE;
            ptr <= ptr_nx;
            busy <= adv;
            done <= adv && ptr_nx == LAST;
            cfg_we <= hit;
            if (hit) begin
                cfg_addr <= ptr_nx;
                cfg_data <= trig[ptr_nx] ? data_in : stage[ptr_nx];
            end
            if (cfg_we) val[cfg_addr] <= cfg_data;
            ovf <= |ovf_hit || (ovf && !clr_ovf);
        end
    end
endmodule
